lane_frame_feeder: RTL and testbench
====================================

Name: lane_frame_feeder

Overview:
Host-side driver for the lane-detection NPU row interface. It buffers a frame of up to MAX_ROWS pixel rows (ROW_BYTES bytes each), then, row by row, pulses the NPU start, streams the row bytes with a valid strobe, and waits for the NPU done pulse. On each done it captures the returned lane-center and confidence bytes into a small result FIFO for downstream logic. It is the transmitting and collecting end of the NPU's start / rx_data / rx_valid / tx_data / confidence / done_signal interface.

Parameters:
ROW_BYTES, 32, bytes per row sent to the NPU; must match the NPU row width.
MAX_ROWS, 16, rows the frame buffer holds.
GAP_CYCLES, 0, idle cycles inserted between consecutive valid bytes (0 = back-to-back).
TIMEOUT, 1024, cycles allowed in WAIT_DONE before the row is aborted.
RES_DEPTH, 4, result FIFO depth (power of 2).

Ports:
clk  in  1  clock
rst  in  1  reset
load_we  in  1  frame-buffer write strobe
load_addr  in  $clog2(MAX_ROWS*ROW_BYTES)  byte address, computed as row*ROW_BYTES+byte
load_data  in  8  pixel byte
frame_start  in  1  begin processing rows 0..num_rows-1
num_rows  in  $clog2(MAX_ROWS+1)  rows in this frame
npu_start  out  1  one-cycle start pulse to NPU
npu_data  out  8  pixel byte to NPU
npu_valid  out  1  npu_data valid
npu_center  in  8  NPU lane center (tx_data)
npu_conf  in  8  NPU confidence
npu_done  in  1  NPU one-cycle done pulse
res_valid  out  1  result FIFO not empty
res_ready  in  1  consumer pop
res_row  out  $clog2(MAX_ROWS)  row index of head result
res_center  out  8  head center
res_conf  out  8  head confidence
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame
timeout_err  out  1  sticky; cleared by the next accepted frame_start

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. During reset all outputs are 0, the FSM goes to IDLE, and the FIFO is emptied. Frame-buffer contents are not cleared.
- Frame-buffer writes: load_we is accepted only when busy=0 and is ignored while busy=1.
- FSM states: IDLE, START, SEND, GAP, WAIT_DONE, CAPTURE, FINISH.
- IDLE: on frame_start, latch min(num_rows, MAX_ROWS), set row=0, set busy=1, and clear timeout_err.
  - If the latched row count is 0, go directly to FINISH.
  - Otherwise go to START.
  - frame_start while busy=1 is ignored.
- START: if the FIFO is full, stall in START with npu_start=0. Otherwise assert npu_start for exactly one cycle, set byte=0, and go to SEND.
- SEND: drive npu_valid=1 and npu_data=buf[row*ROW_BYTES+byte]; this state is never entered in the same cycle as npu_start.
  - With GAP_CYCLES=0, a start pulse at cycle T gives bytes at T+1..T+ROW_BYTES.
  - After the last byte, go to WAIT_DONE.
  - Otherwise go to GAP if GAP_CYCLES>0, else stay in SEND with byte+1.
- GAP: npu_valid=0 for exactly GAP_CYCLES cycles, then return to SEND.
- WAIT_DONE: npu_valid=0 and a cycle counter runs.
  - On npu_done: register npu_center and npu_conf and go to CAPTURE.
  - On the counter reaching TIMEOUT: set timeout_err=1 and go to FINISH. The aborted row pushes no result and remaining rows are skipped.
  - npu_done arriving in any other state is ignored.
- CAPTURE: push {row, center, conf} into the FIFO; space is guaranteed by the START check with one row in flight. Then:
  - if row == rows-1, go to FINISH;
  - otherwise increment row and go to START.
- FINISH: pulse frame_done for one cycle, set busy=0, go to IDLE.
- Result FIFO: first-word fall-through, so res_* always shows the head entry.
  - A pop occurs when res_valid && res_ready.
  - A push and a pop in the same cycle are both honoured.
  - Pointers wrap modulo RES_DEPTH.
  - The FIFO is independent of the FSM and drains during IDLE.
- Reset mid-frame aborts immediately: no frame_done pulse, outputs return to reset values.

Test Plan:
1. Load row0 bytes 0..31 = 8'h10+i; frame_start with num_rows=1; model NPU returns center=14, conf=200 -> npu_start at T; bytes 8'h10..8'h2F on cycles T+1..T+32; res_valid with row=0, center=14, conf=200; frame_done pulses once.
2. GAP_CYCLES=2, one row -> exactly 2 npu_valid=0 cycles between each byte; 32 valid strobes total; the last byte lands at T+1+31*3.
3. num_rows=6, RES_DEPTH=4, res_ready=0 -> 4 results stored; feeder stalls in START with no 5th npu_start. Raising res_ready resumes the frame; 6 results pop in row order 0..5.
4. NPU never pulses done, TIMEOUT=50 -> timeout_err=1 at the 50th WAIT_DONE cycle; frame_done pulses; no result pushed. The next frame_start clears timeout_err.
5. num_rows=0 -> no npu_start; frame_done pulses within 2 cycles of frame_start. num_rows=20 -> clamped to 16 rows.
6. Assert rst during byte 10 of row 2 -> the next cycle shows all outputs 0, FSM in IDLE, FIFO empty; load_we during busy leaves buffer contents unchanged.

Source files
------------

// File: rtl/lane_frame_feeder.sv
// lane_frame_feeder: buffers a pixel frame, feeds it row by row to the lane NPU and queues the returned results
module lane_frame_feeder #(
  parameter int ROW_BYTES = 32,
  parameter int MAX_ROWS = 16,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT = 1024,
  parameter int RES_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_we,
  input  logic [$clog2(MAX_ROWS*ROW_BYTES)-1:0] load_addr,
  input  logic [7:0] load_data,
  input  logic frame_start,
  input  logic [$clog2(MAX_ROWS+1)-1:0] num_rows,
  output logic npu_start,
  output logic [7:0] npu_data,
  output logic npu_valid,
  input  logic [7:0] npu_center,
  input  logic [7:0] npu_conf,
  input  logic npu_done,
  output logic res_valid,
  input  logic res_ready,
  output logic [$clog2(MAX_ROWS)-1:0] res_row,
  output logic [7:0] res_center,
  output logic [7:0] res_conf,
  output logic busy,
  output logic frame_done,
  output logic timeout_err
);
  localparam int AW = $clog2(MAX_ROWS*ROW_BYTES);
  localparam int NW = $clog2(MAX_ROWS+1);
  localparam int IW = $clog2(MAX_ROWS);
  localparam int BW = $clog2(ROW_BYTES);
  localparam int GW = $clog2(GAP_CYCLES+2);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = $clog2(RES_DEPTH+1);
  typedef enum logic [2:0] {IDLE, START, SEND, GAP, WAIT_DONE, CAPTURE, FINISH} state_t;
  state_t state, state_n;
  logic [7:0] pix [MAX_ROWS*ROW_BYTES];
  logic [IW+15:0] fifo [RES_DEPTH];
  logic [NW-1:0] rows, row;
  logic [BW-1:0] bidx;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] cap_center, cap_conf;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_addr;
  logic full, push, pop, last_byte, last_row, timed_out;
  assign rd_addr = AW'(row) * AW'(ROW_BYTES) + AW'(bidx);
  assign last_byte = int'(bidx) == ROW_BYTES - 1;
  assign last_row = row == rows - NW'(1);
  assign timed_out = !npu_done && int'(tcnt) == TIMEOUT - 1;
  assign busy = state != IDLE;
  assign frame_done = state == FINISH;
  assign npu_valid = state == SEND;
  assign npu_data = npu_valid ? pix[rd_addr] : '0;
  assign push = state == CAPTURE;
  assign pop = res_valid && res_ready;
  assign full = int'(cnt) == RES_DEPTH;
  assign res_valid = cnt != '0;
  assign {res_row, res_center, res_conf} = res_valid ? fifo[rp] : '0;
  // host writes land in the frame buffer only between frames
  always_ff @(posedge clk) if (load_we && !busy) pix[load_addr] <= load_data;
  // sequencer state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // sequencer next state and the start pulse; START holds off while the result FIFO is full
  always_comb begin
    state_n = state;
    npu_start = 1'b0;
    case (state)
      IDLE: if (frame_start) state_n = (num_rows == '0) ? FINISH : START;
      START: if (!full) begin
        npu_start = 1'b1;
        state_n = SEND;
      end
      SEND: state_n = last_byte ? WAIT_DONE : (GAP_CYCLES > 0 ? GAP : SEND);
      GAP: if (int'(gcnt) == GAP_CYCLES - 1) state_n = SEND;
      WAIT_DONE: state_n = npu_done ? CAPTURE : (timed_out ? FINISH : WAIT_DONE);
      CAPTURE: state_n = last_row ? FINISH : START;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // row/byte bookkeeping, gap and timeout counters, result capture and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rows <= '0;
      row <= '0;
      bidx <= '0;
      gcnt <= '0;
      tcnt <= '0;
      cap_center <= '0;
      cap_conf <= '0;
      timeout_err <= 1'b0;
    end else begin
      gcnt <= (state == GAP) ? gcnt + GW'(1) : '0;
      tcnt <= (state == WAIT_DONE) ? tcnt + TW'(1) : '0;
      if (state == IDLE && frame_start) begin
        rows <= (int'(num_rows) > MAX_ROWS) ? NW'(MAX_ROWS) : num_rows;
        row <= '0;
        timeout_err <= 1'b0;
      end
      if (state == START) bidx <= '0;
      if (state == SEND && !last_byte) bidx <= bidx + BW'(1);
      if (state == WAIT_DONE && npu_done) begin
        cap_center <= npu_center;
        cap_conf <= npu_conf;
      end
      if (state == WAIT_DONE && timed_out) timeout_err <= 1'b1;
      if (state == CAPTURE && !last_row) row <= row + NW'(1);
    end
  end
  // result FIFO storage; entries need no reset since occupancy gates the outputs
  always_ff @(posedge clk) if (push) fifo[wp] <= {row[IW-1:0], cap_center, cap_conf};
  // result FIFO pointers and occupancy, running independently of the sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_lane_frame_feeder.sv
// tb_lane_frame_feeder: randomized scoreboard bench with a behavioural NPU and frame model
module tb_lane_frame_feeder;
  localparam int RB = 32, MR = 16, GAP = 2, TO = 50, RD = 4;
  logic clk = 0, rst = 1, load_we = 0, frame_start = 0, npu_done = 0, res_ready = 1;
  logic [8:0] load_addr = 0;
  logic [7:0] load_data = 0, npu_center = 0, npu_conf = 0;
  logic [4:0] num_rows = 0;
  logic [7:0] npu_data, res_center, res_conf;
  logic [3:0] res_row;
  logic npu_start, npu_valid, res_valid, busy, frame_done, timeout_err;
  logic [7:0] shadow [MR*RB];
  logic [7:0] cen_tab [MR];
  logic [7:0] conf_tab [MR];
  logic [19:0] expq [$];
  int vecs = 0, errs = 0, cyc = 0, st_cnt = 0, nbytes = 0, st_cyc = 0, last_byte_cyc = 0;
  int done_at = 0, fd_cnt = 0, fd_cyc = 0, fs_cyc = 0, pops = 0;
  bit pending = 0, mute = 0, to_at_fd = 0;

  lane_frame_feeder #(.ROW_BYTES(RB), .MAX_ROWS(MR), .GAP_CYCLES(GAP), .TIMEOUT(TO), .RES_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .frame_start(frame_start), .num_rows(num_rows), .npu_start(npu_start), .npu_data(npu_data),
    .npu_valid(npu_valid), .npu_center(npu_center), .npu_conf(npu_conf), .npu_done(npu_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_center(res_center),
    .res_conf(res_conf), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    load_we = 1;
    load_addr = 9'(a);
    load_data = d;
    tick();
    load_we = 0;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    shadow[a] = d;
    write_byte(a, d);
  endtask

  task automatic randomize_results();
    for (int r = 0; r < MR; r++) begin
      cen_tab[r] = 8'($urandom);
      conf_tab[r] = 8'($urandom);
    end
  endtask

  task automatic start_frame(input int n);
    st_cnt = 0;
    num_rows = 5'(n);
    frame_start = 1;
    fs_cyc = cyc;
    tick();
    frame_start = 0;
  endtask

  task automatic wait_frame(input int f0);
    int t = 0;
    while (fd_cnt == f0 && t < 4000) begin
      tick();
      t++;
    end
    check("frame_done_seen", fd_cnt != f0, 1);
    repeat (4) tick();
    check("frame_done_once", fd_cnt - f0, 1);
  endtask

  task automatic run_frame(input int n, input int exp_rows);
    int p0 = pops, f0 = fd_cnt;
    start_frame(n);
    wait_frame(f0);
    check("row_starts", st_cnt, exp_rows);
    check("results_popped", pops - p0, exp_rows);
    check("scoreboard_empty", expq.size(), 0);
  endtask

  // NPU model: checks each byte's value and arrival cycle, answers each full row after a random delay
  initial forever begin
    @(negedge clk);
    npu_done = 0;
    if (rst) begin
      nbytes = 0;
      pending = 0;
    end else begin
      if (npu_start) begin
        st_cnt++;
        st_cyc = cyc;
        nbytes = 0;
      end
      if (npu_valid) begin
        check("npu_data", npu_data, shadow[(st_cnt - 1) * RB + nbytes]);
        check("byte_cycle", cyc - st_cyc, 1 + nbytes * (GAP + 1));
        nbytes++;
        if (nbytes == RB) begin
          last_byte_cyc = cyc;
          pending = !mute;
          done_at = cyc + $urandom_range(1, 20);
        end
      end
      if (pending && cyc == done_at) begin
        pending = 0;
        npu_done = 1;
        npu_center = cen_tab[st_cnt - 1];
        npu_conf = conf_tab[st_cnt - 1];
        expq.push_back({4'(st_cnt - 1), cen_tab[st_cnt - 1], conf_tab[st_cnt - 1]});
      end
    end
  end

  // result monitor: every pop must match the oldest expected result
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        to_at_fd = timeout_err;
      end
      if (res_valid && res_ready) begin
        pops++;
        if (expq.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e = expq.pop_front();
          check("res_row", res_row, e[19:16]);
          check("res_center", res_center, e[15:8]);
          check("res_conf", res_conf, e[7:0]);
        end
      end
    end
  end

  initial begin
    int p0, f0, t;
    repeat (3) tick();
    @(negedge clk);
    check("reset_ctrl", {npu_start, npu_valid, res_valid, busy, frame_done, timeout_err}, 0);
    check("reset_data", {npu_data, res_row, res_center, res_conf}, 0);
    tick();
    rst = 0;
    for (int i = 0; i < RB; i++) load(i, 8'(8'h10 + i));
    for (int i = RB; i < MR * RB; i++) load(i, 8'($urandom));
    cen_tab[0] = 8'd14;
    conf_tab[0] = 8'd200;
    run_frame(1, 1);
    for (int k = 0; k < 4; k++) begin
      randomize_results();
      t = $urandom_range(1, MR);
      run_frame(t, t);
    end
    randomize_results();
    res_ready = 0;
    p0 = pops;
    f0 = fd_cnt;
    start_frame(6);
    repeat (700) tick();
    check("stall_starts", st_cnt, RD);
    check("stall_busy", busy, 1);
    check("stall_res_valid", res_valid, 1);
    res_ready = 1;
    wait_frame(f0);
    check("stall_total_starts", st_cnt, 6);
    check("stall_pops", pops - p0, 6);
    check("stall_scoreboard_empty", expq.size(), 0);
    mute = 1;
    p0 = pops;
    f0 = fd_cnt;
    start_frame(3);
    wait_frame(f0);
    mute = 0;
    check("timeout_flag_at_done", to_at_fd, 1);
    check("timeout_latency", fd_cyc - last_byte_cyc, TO + 1);
    check("timeout_starts", st_cnt, 1);
    check("timeout_no_result", pops - p0, 0);
    check("timeout_sticky", timeout_err, 1);
    randomize_results();
    p0 = pops;
    f0 = fd_cnt;
    start_frame(1);
    check("timeout_cleared", timeout_err, 0);
    wait_frame(f0);
    check("after_timeout_pops", pops - p0, 1);
    f0 = fd_cnt;
    start_frame(0);
    wait_frame(f0);
    check("empty_frame_starts", st_cnt, 0);
    check("empty_frame_latency", (fd_cyc - fs_cyc) <= 2, 1);
    randomize_results();
    run_frame(20, MR);
    f0 = fd_cnt;
    start_frame(4);
    t = 0;
    while (!(st_cnt == 3 && nbytes == 10) && t < 3000) begin
      tick();
      t++;
    end
    check("reached_row2_byte10", st_cnt == 3 && nbytes == 10, 1);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("midframe_reset_ctrl", {npu_start, npu_valid, res_valid, busy, frame_done, timeout_err}, 0);
    check("midframe_reset_data", {npu_data, res_row, res_center, res_conf}, 0);
    expq.delete();
    repeat (5) tick();
    check("midframe_reset_no_done", fd_cnt - f0, 0);
    randomize_results();
    p0 = pops;
    f0 = fd_cnt;
    start_frame(1);
    write_byte(5, ~shadow[5]);
    wait_frame(f0);
    check("busy_write_starts", st_cnt, 1);
    check("busy_write_pops", pops - p0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
